organ_keypad_scanner: RTL and testbench

- Input-side counterpart of the organ's dot-matrix display driver.
- Scans a 4x4 active-low matrix keypad, debounces it, and decodes key presses into the organ's note and tone encodings: `value_input` (3 bits, 001=do .. 111=si, 000=none) and `tone_input` (00 low, 10 mid, 11 high).
- Also owns the play/input `state` toggle.
- Outputs feed the display driver and the tone generator directly.

---
 rtl/organ_pkg.sv | 42 ++++
 rtl/organ_keypad_scanner_if.sv | 22 ++
 rtl/organ_key_debounce.sv | 100 ++++++++++
 rtl/organ_keypad_scanner.sv | 122 ++++++++++++
 tb/tb_organ_keypad_scanner.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/organ_pkg.sv
// Shared organ encodings: note/tone codes, keypad map and key-debounce FSM states.
// Used by the keypad scanner, the display driver and the tone generator.
package organ_pkg;

    localparam logic [1:0] TONE_LOW  = 2'b00;
    localparam logic [1:0] TONE_MID  = 2'b10;
    localparam logic [1:0] TONE_HIGH = 2'b11;

    localparam logic [2:0] VALUE_NONE = 3'b000;

    // Key codes are {row[1:0], col[1:0]}; (3,3) is never a live key so it doubles as the sentinel.
    localparam logic [3:0] KEY_NONE      = 4'hF;
    localparam logic [3:0] KEY_UNUSED    = 4'h7;
    localparam logic [3:0] KEY_TONE_LOW  = 4'h8;
    localparam logic [3:0] KEY_TONE_MID  = 4'h9;
    localparam logic [3:0] KEY_TONE_HIGH = 4'hA;
    localparam logic [3:0] KEY_MODE      = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEB,
        ST_PRESSED,
        ST_REL
    } deb_state_e;

    function automatic logic [3:0] key_map(input logic [3:0] raw);
        if (raw[3:2] == 2'b11 || raw == KEY_UNUSED) begin
            return KEY_NONE;
        end
        return raw;
    endfunction

    function automatic logic key_is_note(input logic [3:0] k);
        return (k[3] == 1'b0) && (k != KEY_UNUSED);
    endfunction

    // Keys 0..6 map to notes do..si (001..111).
    function automatic logic [2:0] key_note(input logic [3:0] k);
        return k[2:0] + 3'd1;
    endfunction

endpackage

// File: rtl/organ_keypad_scanner_if.sv
// Keypad matrix lines plus the decoded note/tone/mode outputs of the scanner.
interface organ_keypad_scanner_if;

    logic [3:0] kbd_col;
    logic [3:0] kbd_row;
    logic [2:0] value;
    logic [1:0] tone;
    logic       state;
    logic       key_valid;
    logic [3:0] key_code;

    modport master (
        input  kbd_col,
        output kbd_row, value, tone, state, key_valid, key_code
    );

    modport slave (
        output kbd_col,
        input  kbd_row, value, tone, state, key_valid, key_code
    );

endinterface

// File: rtl/organ_key_debounce.sv
// Per-frame press/release debouncer: a key must be seen (or missed) for
// DEBOUNCE_FRAMES consecutive frames before it is accepted (or released).
module organ_key_debounce
    import organ_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_end_i,
    input  logic [3:0] frame_result_i,
    output logic       accept_o,
    output logic       release_o,
    output logic [3:0] cand_o
);

    localparam logic [3:0] CNT_TGT = 4'(DEBOUNCE_FRAMES);

    deb_state_e state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cand_q  <= KEY_NONE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        accept_o  = 1'b0;
        release_o = 1'b0;
        if (frame_end_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_result_i != KEY_NONE) begin
                        cand_d = frame_result_i;
                        cnt_d  = 4'd1;
                        if (CNT_TGT == 4'd1) begin
                            accept_o = 1'b1;
                            state_d  = ST_PRESSED;
                        end else begin
                            state_d  = ST_DEB;
                        end
                    end
                end
                ST_DEB: begin
                    if (frame_result_i == cand_q) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == CNT_TGT) begin
                            accept_o = 1'b1;
                            state_d  = ST_PRESSED;
                        end
                    end else if (frame_result_i == KEY_NONE) begin
                        cnt_d   = 4'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cand_d = frame_result_i;
                        cnt_d  = 4'd1;
                    end
                end
                ST_PRESSED: begin
                    if (frame_result_i != cand_q) begin
                        cnt_d = 4'd1;
                        if (CNT_TGT == 4'd1) begin
                            release_o = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            state_d   = ST_REL;
                        end
                    end
                end
                ST_REL: begin
                    if (frame_result_i != cand_q) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == CNT_TGT) begin
                            release_o = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // cand_d is the accepted key even when acceptance happens straight out of IDLE.
    assign cand_o = cand_d;

endmodule

// File: rtl/organ_keypad_scanner.sv
// 4x4 active-low keypad scanner: row drive, column sync, frame decode and
// the note/tone/mode registers fed by the per-frame debouncer.
module organ_keypad_scanner
    import organ_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    organ_keypad_scanner_if.master        kbd_if
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [3:0]       col_s1_q, col_s2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       row_q, row_d;
    logic             hit_q;
    logic [3:0]       hit_key_q;
    logic [2:0]       value_q;
    logic [1:0]       tone_q;
    logic             mode_q;
    logic             key_valid_q;
    logic [3:0]       key_code_q;

    logic             tc;
    logic             prev_hit, cur_hit, scan_hit;
    logic [3:0]       scan_key;
    logic             frame_end;
    logic [3:0]       frame_result;
    logic             accept, release_k;
    logic [3:0]       cand;

    function automatic logic [1:0] first_low(input logic [3:0] col);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    assign tc    = (div_q == DIV_W'(SCAN_DIV - 1));
    assign div_d = tc ? '0 : div_q + 1'b1;
    assign row_d = tc ? row_q + 2'd1 : row_q;

    // Earlier rows of the current frame win; row 0 always starts a fresh search.
    assign prev_hit     = hit_q && (row_q != 2'd0);
    assign cur_hit      = (col_s2_q != 4'hF);
    assign scan_hit     = prev_hit || cur_hit;
    assign scan_key     = prev_hit ? hit_key_q : {row_q, first_low(col_s2_q)};
    assign frame_end    = tc && (row_q == 2'd3);
    assign frame_result = scan_hit ? key_map(scan_key) : KEY_NONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_s1_q  <= 4'hF;
            col_s2_q  <= 4'hF;
            div_q     <= '0;
            row_q     <= 2'd0;
            hit_q     <= 1'b0;
            hit_key_q <= KEY_NONE;
        end else begin
            col_s1_q <= kbd_if.kbd_col;
            col_s2_q <= col_s1_q;
            div_q    <= div_d;
            row_q    <= row_d;
            if (tc) begin
                hit_q     <= scan_hit;
                hit_key_q <= scan_key;
            end
        end
    end

    organ_key_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk            (clk),
        .rst            (rst),
        .frame_end_i    (frame_end),
        .frame_result_i (frame_result),
        .accept_o       (accept),
        .release_o      (release_k),
        .cand_o         (cand)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q     <= VALUE_NONE;
            tone_q      <= TONE_MID;
            mode_q      <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
        end else begin
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= cand;
                if (key_is_note(cand)) begin
                    value_q <= key_note(cand);
                end
                case (cand)
                    KEY_TONE_LOW:  tone_q <= TONE_LOW;
                    KEY_TONE_MID:  tone_q <= TONE_MID;
                    KEY_TONE_HIGH: tone_q <= TONE_HIGH;
                    KEY_MODE:      mode_q <= ~mode_q;
                    default: ;
                endcase
            end else if (release_k && key_is_note(cand)) begin
                value_q <= VALUE_NONE;
            end
        end
    end

    assign kbd_if.kbd_row   = ~(4'b0001 << row_q);
    assign kbd_if.value     = value_q;
    assign kbd_if.tone      = tone_q;
    assign kbd_if.state     = mode_q;
    assign kbd_if.key_valid = key_valid_q;
    assign kbd_if.key_code  = key_code_q;

endmodule

// File: tb/tb_organ_keypad_scanner.sv
// Directed bench for the keypad scanner with a behavioural 4x4 matrix model
// (SCAN_DIV=4, DEBOUNCE_FRAMES=3, 16-cycle frames).
module tb_organ_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] key_mat = 16'h0;
    logic [3:0]  col_v;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          kv_cnt  = 0;
    int          kv_base;
    int          lat;
    logic [3:0]  exp_row;

    organ_keypad_scanner_if kbd_if ();

    organ_keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .kbd_if (kbd_if)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row line to its column line.
    always_comb begin
        col_v = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (kbd_if.kbd_row[r] == 1'b0 && key_mat[r*4+c]) col_v[c] = 1'b0;
            end
        end
    end
    assign kbd_if.kbd_col = col_v;

    always @(negedge clk) begin
        if (kbd_if.key_valid === 1'b1) kv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int r, input int c);
        key_mat[r*4+c] = 1'b1;
    endtask

    task automatic sync_frame();
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        prev  = kbd_if.kbd_row;
        for (int i = 0; i < 64 && !found; i++) begin
            tick();
            if (prev == 4'b0111 && kbd_if.kbd_row == 4'b1110) found = 1'b1;
            prev = kbd_if.kbd_row;
        end
        chk("frame_sync", {31'd0, found}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_row"},   kbd_if.kbd_row,   4'b1110);
        chk({tag, "_value"}, kbd_if.value,     3'b000);
        chk({tag, "_tone"},  kbd_if.tone,      2'b10);
        chk({tag, "_state"}, kbd_if.state,     1'b0);
        chk({tag, "_kv"},    kbd_if.key_valid, 1'b0);
        chk({tag, "_code"},  kbd_if.key_code,  4'h0);
    endtask

    initial begin
        // 1: reset values and row stepping
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("t1_por");
        @(negedge clk) rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            chk("t1_row_step", kbd_if.kbd_row, exp_row);
        end
        repeat (6) tick();
        chk("t1_row_mid", kbd_if.kbd_row, 4'b1101);
        @(negedge clk) rst = 1'b1;
        #1 chk_reset_outputs("t1_mid");
        @(negedge clk) rst = 1'b0;

        // 2: single note press, latency and release
        sync_frame();
        kv_base = kv_cnt;
        press(0, 2);
        lat = 0;
        for (int n = 1; n <= 64 && lat == 0; n++) begin
            tick();
            if (kbd_if.key_valid) lat = n;
        end
        chk("t2_latency", lat, 48);
        chk("t2_value", kbd_if.value, 3'b011);
        chk("t2_code", kbd_if.key_code, 4'b0010);
        tick();
        chk("t2_pulse_width", kbd_if.key_valid, 1'b0);
        repeat (32) tick();
        chk("t2_pulses", kv_cnt - kv_base, 1);
        sync_frame();
        key_mat = 16'h0;
        repeat (47) tick();
        chk("t2_value_held", kbd_if.value, 3'b011);
        tick();
        chk("t2_value_rel", kbd_if.value, 3'b000);

        // 3: bouncing key on alternate frames never accepted
        sync_frame();
        kv_base = kv_cnt;
        for (int i = 0; i < 12; i++) begin
            key_mat = (i % 2 == 0) ? 16'h0001 : 16'h0000;
            repeat (16) tick();
        end
        key_mat = 16'h0;
        repeat (16) tick();
        chk("t3_value", kbd_if.value, 3'b000);
        chk("t3_pulses", kv_cnt - kv_base, 0);

        // 4: tone keys latch the octave, value untouched
        press(2, 2);
        repeat (64) tick();
        chk("t4_tone_high", kbd_if.tone, 2'b11);
        chk("t4_value_a", kbd_if.value, 3'b000);
        chk("t4_code", kbd_if.key_code, 4'b1010);
        key_mat = 16'h0;
        repeat (64) tick();
        chk("t4_tone_held", kbd_if.tone, 2'b11);
        chk("t4_value_b", kbd_if.value, 3'b000);
        press(2, 0);
        repeat (64) tick();
        chk("t4_tone_low", kbd_if.tone, 2'b00);
        key_mat = 16'h0;
        repeat (64) tick();

        // 5: mode key toggles once per press
        kv_base = kv_cnt;
        press(2, 3);
        repeat (160) tick();
        chk("t5_state_hold", kbd_if.state, 1'b1);
        chk("t5_pulses_hold", kv_cnt - kv_base, 1);
        key_mat = 16'h0;
        repeat (64) tick();
        chk("t5_state_rel", kbd_if.state, 1'b1);
        press(2, 3);
        repeat (64) tick();
        chk("t5_state_again", kbd_if.state, 1'b0);
        chk("t5_pulses", kv_cnt - kv_base, 2);
        key_mat = 16'h0;
        repeat (64) tick();

        // 6: lowest-index priority, then reset during debounce
        press(1, 0);
        press(0, 1);
        repeat (64) tick();
        chk("t6_priority_value", kbd_if.value, 3'b010);
        chk("t6_priority_code", kbd_if.key_code, 4'b0001);
        key_mat = 16'h0;
        repeat (64) tick();
        chk("t6_value_rel", kbd_if.value, 3'b000);
        sync_frame();
        kv_base = kv_cnt;
        press(0, 3);
        repeat (37) tick();
        @(negedge clk) rst = 1'b1;
        #1 chk_reset_outputs("t6_rst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (40) tick();
        chk("t6_no_pulse", kv_cnt - kv_base, 0);
        chk("t6_value_cleared", kbd_if.value, 3'b000);
        repeat (16) tick();
        chk("t6_fresh_accept", kbd_if.value, 3'b100);
        chk("t6_fresh_pulses", kv_cnt - kv_base, 1);
        key_mat = 16'h0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
